// File: rtl/rocket_trace_pkg.sv
// rtl/rocket_trace_pkg.sv - shared types and constants for the Rocket trace writer
package rocket_trace_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    localparam int ENTRY_WIDTH  = 64;
    localparam int ENTRY_STRIDE = 8;

    // Memory image of one trace record: instruction word above the PC.
    function automatic logic [ENTRY_WIDTH-1:0] pack_entry(input logic [31:0] pc,
                                                          input logic [31:0] insn);
        return {insn, pc};
    endfunction

endpackage

// File: rtl/rocket_trace_fifo.sv
// rtl/rocket_trace_fifo.sv - synchronous capture FIFO with flush; a pop frees a slot for a same-cycle push
module rocket_trace_fifo #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_push;
    logic                do_pop;
    logic [DEPTH_LOG2-1:0] wr_idx;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_pop   = pop && !empty && !flush;
    // A push that coincides with a flush lands in the freshly emptied FIFO.
    assign do_push  = push && (flush || !full || do_pop);
    assign wr_idx   = flush ? '0 : wr_ptr[DEPTH_LOG2-1:0];
    assign pop_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? (DEPTH_LOG2+1)'(1) : '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (DEPTH_LOG2+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/rocket_trace_writer.sv
// rtl/rocket_trace_writer.sv - captures retired-instruction records and writes them to a memory ring
// Optional ROCKET_TRACE_DROP_CNT_EN adds trace_drop_count_o (records lost to a full FIFO).
module rocket_trace_writer
    import rocket_trace_pkg::*;
#(
    parameter int                              ROCKET_MEM_ADDR_SIZE = 32,
    parameter logic [ROCKET_MEM_ADDR_SIZE-1:0] TRACE_BASE_ADDR      = 32'h0010_0000,
    parameter int                              TRACE_ENTRIES_LOG2   = 10,
    parameter int                              FIFO_DEPTH_LOG2      = 3
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            trace_enabled_i,
    input  logic                            trace_valid_i,
    input  logic [31:0]                     trace_pc_i,
    input  logic [31:0]                     trace_insn_i,
    output logic                            mem_req_o,
    output logic [ROCKET_MEM_ADDR_SIZE-1:0] mem_addr_o,
    output logic [63:0]                     mem_wdata_o,
    input  logic                            mem_gnt_i,
    output logic [ROCKET_MEM_ADDR_SIZE-1:0] trace_ptr_o,
    output logic [ROCKET_MEM_ADDR_SIZE-1:0] trace_count_o,
    output logic                            trace_busy_o
`ifdef ROCKET_TRACE_DROP_CNT_EN
    ,
    output logic [31:0]                     trace_drop_count_o
`endif
);

    state_t                          state;
    state_t                          state_next;
    logic                            en_q;
    logic                            edge_pend;
    logic                            clear_now;
    logic                            cap_valid;
    logic [ENTRY_WIDTH-1:0]          cap_data;
    logic [ENTRY_WIDTH-1:0]          head_data;
    logic [ENTRY_WIDTH-1:0]          out_data;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic                            load;
    logic                            pop;
    logic [TRACE_ENTRIES_LOG2-1:0]   slot;
    logic [ROCKET_MEM_ADDR_SIZE-1:0] count;

    // A rising enable restarts the session, but only once no write is in flight.
    assign clear_now = (state == ST_IDLE) && (edge_pend || (trace_enabled_i && !en_q));

    // The head stays resident until granted, so the in-flight record occupies a FIFO slot.
    rocket_trace_fifo #(
        .WIDTH      (ENTRY_WIDTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (reset_i),
        .flush     (clear_now),
        .push      (cap_valid),
        .push_data (cap_data),
        .pop       (pop),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!fifo_empty && !clear_now) state_next = ST_WRITE;
            ST_WRITE: if (mem_gnt_i) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o = 1'b0;
        load      = 1'b0;
        pop       = 1'b0;
        case (state)
            ST_IDLE:  load = !fifo_empty && !clear_now;
            ST_WRITE: begin
                mem_req_o = 1'b1;
                pop       = mem_gnt_i;
            end
            default:  ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            en_q      <= 1'b0;
            edge_pend <= 1'b0;
            cap_valid <= 1'b0;
            cap_data  <= '0;
            out_data  <= '0;
            slot      <= '0;
            count     <= '0;
        end else begin
            en_q      <= trace_enabled_i;
            edge_pend <= (edge_pend || (trace_enabled_i && !en_q)) && !clear_now;
            cap_valid <= en_q && trace_valid_i;
            cap_data  <= pack_entry(trace_pc_i, trace_insn_i);
            if (load) out_data <= head_data;
            if (clear_now) begin
                slot  <= '0;
                count <= '0;
            end else if (pop) begin
                slot <= slot + TRACE_ENTRIES_LOG2'(1);
                if (count != '1) count <= count + ROCKET_MEM_ADDR_SIZE'(1);
            end
        end
    end

    assign trace_ptr_o   = TRACE_BASE_ADDR +
                           ROCKET_MEM_ADDR_SIZE'(slot) * ROCKET_MEM_ADDR_SIZE'(ENTRY_STRIDE);
    assign trace_count_o = count;
    assign mem_addr_o    = trace_ptr_o;
    assign mem_wdata_o   = out_data;
    assign trace_busy_o  = !fifo_empty || (state == ST_WRITE);

`ifdef ROCKET_TRACE_DROP_CNT_EN
    logic [31:0] drop_count;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            drop_count <= '0;
        end else if (clear_now) begin
            drop_count <= '0;
        end else if (cap_valid && fifo_full && !pop && drop_count != '1) begin
            drop_count <= drop_count + 32'd1;
        end
    end

    assign trace_drop_count_o = drop_count;
`endif

endmodule

// File: doc/rocket_trace_writer.md
Name: rocket_trace_writer

Overview:
Captures retired-instruction trace records from the Rocket core into a small FIFO. Drains them as 64-bit single-beat writes into a ring buffer in tile memory. Sits directly upstream of the Rocket register file:
- consumes its trace-enable bit;
- produces the trace pointer and trace count that software reads back through the register interface.

Parameters:
ROCKET_MEM_ADDR_SIZE, 32, width of memory addresses and of ptr/count outputs
TRACE_BASE_ADDR, 32'h0010_0000, byte address of ring buffer start (8-byte aligned)
TRACE_ENTRIES_LOG2, 10, log2 of ring size in 8-byte entries (1024 entries = 8 KiB)
FIFO_DEPTH_LOG2, 3, log2 of capture FIFO depth (8 entries)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
trace_enabled_i  in  1  trace enable from register file
trace_valid_i  in  1  core retired an instruction this cycle
trace_pc_i  in  32  PC of retired instruction
trace_insn_i  in  32  encoding of retired instruction
mem_req_o  out  1  write request to memory
mem_addr_o  out  ROCKET_MEM_ADDR_SIZE  byte address of write
mem_wdata_o  out  64  write data {insn[31:0], pc[31:0]}
mem_gnt_i  in  1  memory accepted current write
trace_ptr_o  out  ROCKET_MEM_ADDR_SIZE  byte address of next ring slot to be written
trace_count_o  out  ROCKET_MEM_ADDR_SIZE  entries written since last enable, saturating
trace_busy_o  out  1  FIFO non-empty or write outstanding

Behaviour:
- Reset (async, active-high). Clears FIFO, FSM, counters and the enable-edge register. Output values during reset:
  - mem_req_o=0, mem_addr_o=TRACE_BASE_ADDR, mem_wdata_o=0;
  - trace_ptr_o=TRACE_BASE_ADDR, trace_count_o=0, trace_busy_o=0.
  - A write in flight is abandoned, with no partial effect.
- Enable edge:
  - trace_enabled_i is registered.
  - On a 0->1 transition, ptr returns to TRACE_BASE_ADDR and count to 0 in the following cycle.
  - FIFO contents left from an earlier session are flushed on that edge.
  - An outstanding request completes first: the flush takes effect in IDLE only. The edge is held pending until then.
- Capture:
  - When registered enable=1 and trace_valid_i=1, {insn,pc} is pushed one cycle later. Capture latency is 1 cycle.
  - Push when full: the record is dropped and the FIFO is unchanged.
  - Simultaneous push and pop when full: the pop frees a slot, so the push succeeds.
- Disable: when enable is 0, no captures occur, but the FIFO keeps draining until empty. ptr and count remain readable.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head into the output register and go to WRITE in the next cycle.
  - WRITE: mem_req_o=1, with addr and wdata held stable until mem_gnt_i.
  - On gnt:
    - ptr advances by 8;
    - count increments, saturating at all-ones;
    - return to IDLE.
  - Minimum of 2 cycles per record; back-to-back requests are not required.
- mem_req_o never deasserts before mem_gnt_i. A gnt while req=0 is ignored.
- Ring wrap: ptr = TRACE_BASE_ADDR + (slot << 3), where slot is a TRACE_ENTRIES_LOG2-bit counter that wraps from 2^TRACE_ENTRIES_LOG2-1 to 0. count does not wrap.
- trace_ptr_o and trace_count_o are registered and update in the cycle after gnt.
- trace_busy_o = FIFO non-empty OR state==WRITE.

Optional Feature:
ROCKET_TRACE_DROP_CNT_EN.
- Defined:
  - Adds output trace_drop_count_o [31:0], counting records discarded on push-when-full.
  - Saturates at all-ones, resets to 0, and clears on the enable 0->1 edge, like count.
  - The register file maps this output at a new read-only register.
- Undefined: the port and counter are absent, and drops are silent.

Decomposition:
- Package rocket_trace_pkg holds:
  - FSM state encoding (IDLE/WRITE);
  - entry width 64;
  - entry byte stride 8;
  - the entry packing order {insn,pc}.
- Sub-module rocket_trace_fifo: synchronous FIFO with parameters width and depth-log2. Ports push/pop/full/empty/data, plus a flush input.

Test Plan:
- 3 valid retirements with enable=1 and gnt delayed 2 cycles each -> 3 writes to 0x100000, 0x100008 and 0x100010 with matching {insn,pc}; ptr=0x100018, count=3.
- 1025 records with TRACE_ENTRIES_LOG2=10 -> the 1025th write goes to 0x100000 (wrap); ptr=0x100008, count=1025.
- 12 consecutive valid cycles with gnt held low -> 8 records stored and 4 dropped; after gnt is released, exactly 8 writes occur. With DROP_CNT_EN, trace_drop_count_o=4.
- Enable dropped mid-burst, then raised again after drain -> remaining FIFO entries written before busy falls; the re-enable edge resets ptr=0x100000, count=0.
- reset_i pulsed while mem_req_o=1 -> req drops asynchronously and all outputs take their reset values. After release, no write is issued until a new trace_valid_i.
- trace_valid_i with enable=0 -> no writes, busy stays 0, count unchanged.
